// File: rtl/median_pkg.sv
// Shared definitions for the streaming median filter.
//   state_t   : controller states (IDLE accepting, SORT sorting, OUT presenting)
//   DEF_WIDTH : default sample width
//   DEF_N     : default window length (odd, >= 3)
//   IDX_W     : fill-count / sort-step width for the default window
//   idx_w()   : same width for an arbitrary window length
package median_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N     = 5;
  localparam int IDX_W     = $clog2(DEF_N + 1);

  typedef enum logic [1:0] {IDLE, SORT, OUT} state_t;

  // Counters must reach N itself (saturated fill count, final sort step).
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/median_cmp_swap.sv
// Unsigned compare-and-swap cell.
//   a, b   : operands
//   lo, hi : min / max of the operands; equal operands pass straight through
module median_cmp_swap #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);
  logic swap;

  assign swap = a > b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;
endmodule

// File: rtl/median_window_filter.sv
// Streaming median of the last N unsigned samples.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : sample handshake, in_data carries the sample
//   out_valid/out_ready : median handshake, out_data carries the median
// Each accepted sample (once N have been seen) is sorted by N passes of an
// odd-even transposition network built from N/2 compare-swap cells; the
// block stalls input from the accept until the median is taken.
module median_window_filter
  import median_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N     = DEF_N
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  localparam int            CW  = idx_w(N);
  localparam int            NP  = N / 2;
  localparam logic [CW-1:0] N_C = CW'(N);

  state_t                     state;
  logic [CW-1:0]              cnt, step;
  logic [N-1:0][WIDTH-1:0]    win, win_nxt, srt, srt_nxt;
  logic [NP-1:0][WIDTH-1:0]   ca, cb, clo, chi;
  logic                       odd;

  // Newest sample enters at index 0, oldest falls off the top.
  assign win_nxt = {win[N-2:0], in_data};
  assign odd     = step[0];

  // Cell k serves pair (2k,2k+1) on even steps and (2k+1,2k+2) on odd
  // steps; with N odd both phases need exactly N/2 cells.
  for (genvar k = 0; k < NP; k++) begin : g_cs
    assign ca[k] = odd ? srt[2*k+1] : srt[2*k];
    assign cb[k] = odd ? srt[2*k+2] : srt[2*k+1];

    median_cmp_swap #(.WIDTH(WIDTH)) u_cs (
      .a  (ca[k]),
      .b  (cb[k]),
      .lo (clo[k]),
      .hi (chi[k])
    );
  end

  always_comb begin
    srt_nxt = srt;
    for (int k = 0; k < NP; k++) begin
      if (odd) begin
        srt_nxt[2*k+1] = clo[k];
        srt_nxt[2*k+2] = chi[k];
      end else begin
        srt_nxt[2*k]   = clo[k];
        srt_nxt[2*k+1] = chi[k];
      end
    end
  end

  // Steps 0..N-1 run the passes; the extra step==N cycle captures the
  // middle element from the settled sort registers, so out_data is fed by
  // a register rather than by the compare-swap outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= '0;
      win       <= '0;
      srt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            win <= win_nxt;
            if (cnt != N_C) cnt <= cnt + 1'b1;
            if (cnt >= N_C - 1'b1) begin
              srt      <= win_nxt;
              step     <= '0;
              in_ready <= 1'b0;
              state    <= SORT;
            end
          end
        end
        SORT: begin
          if (step == N_C) begin
            out_data  <= srt[N/2];
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            srt  <= srt_nxt;
            step <= step + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_median_window_filter.sv
module tb_median_window_filter;
  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] win_q[$];

  median_window_filter #(.WIDTH(8), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: median of the last N samples by plain sorting.
  function automatic logic [7:0] ref_median();
    int a[N];
    int t;
    for (int i = 0; i < N; i++) a[i] = int'(win_q[i]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    return 8'(a[N/2]);
  endfunction

  task automatic model_push(input logic [7:0] v);
    win_q.push_front(v);
    if (win_q.size() > N) void'(win_q.pop_back());
  endtask

  task automatic accept(input logic [7:0] v);
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    chk("accept_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(v);
  endtask

  // out_valid must rise exactly N+1 edges after the accept edge.
  task automatic expect_median();
    logic [7:0] e;
    e = ref_median();
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      chk("lat_early", out_valid, 0);
      chk("busy_rdy", in_ready, 0);
    end
    @(posedge clk); #1;
    chk("lat_valid", out_valid, 1);
    chk("median", out_data, e);
  endtask

  task automatic handshake();
    @(posedge clk); #1;
    chk("hs_valid", out_valid, 0);
    chk("hs_rdy", in_ready, 1);
  endtask

  task automatic push(input logic [7:0] v);
    accept(v);
    if (win_q.size() == N) begin
      expect_median();
      handshake();
    end else begin
      chk("fill_valid", out_valid, 0);
      chk("fill_rdy", in_ready, 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bp_e;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    rst_n = 1'b1;

    // fill then slide: medians 30, 30, 30, 20
    push(8'd10); push(8'd50); push(8'd30); push(8'd20); push(8'd40);
    push(8'd5); push(8'd255); push(8'd0);

    // duplicates and extremes
    repeat (5) push(8'd7);
    push(8'd0); push(8'd255); push(8'd0); push(8'd255); push(8'd128);
    repeat (5) push(8'd255);

    // newest-first window 50,40,30,20,10 is fully reversed for the sorter
    push(8'd10); push(8'd20); push(8'd30); push(8'd40); push(8'd50);

    // back-pressure: hold the median 3 cycles while a sample waits upstream
    out_ready = 1'b0;
    accept(8'd60);
    expect_median();
    bp_e = ref_median();
    in_valid = 1'b1;
    in_data  = 8'd99;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, bp_e);
      chk("bp_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    handshake();
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_push(8'd99);
    expect_median();
    handshake();

    // reset in the middle of SORT (step 2)
    accept(8'd77);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", in_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    #2 rst_n = 1'b1;
    win_q.delete();
    push(8'd3); push(8'd200); push(8'd90); push(8'd90); push(8'd1);

    // randomized traffic, biased toward duplicates and extremes
    repeat (40) begin
      logic [7:0] v;
      case ($urandom_range(0, 3))
        0:       v = 8'($urandom_range(0, 2));
        1:       v = 8'($urandom_range(253, 255));
        default: v = 8'($urandom_range(0, 255));
      endcase
      push(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
